// File: rtl/signed_sat_accumulator_if.sv
// Valid/ready stream bundle for signed_sat_accumulator: sample input side and frame-result output side.
interface signed_sat_accumulator_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;

  // Producer/consumer environment drives samples and takes results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/signed_sat_accumulator.sv
// Streaming frame accumulator: folds FRAME_LEN signed samples into a saturating sum
// and holds the result (with a sticky saturation flag) until the consumer accepts it.
module signed_sat_accumulator #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  signed_sat_accumulator_if.slave s
);

  localparam int               CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_ACC, ST_HOLD} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             ovf;
  } sat_res_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  sat_res_t         add_res;

  // Overflow is judged from operand signs against the wrapped sum's sign.
  function automatic sat_res_t sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    sat_res_t         r;
    logic [WIDTH-1:0] raw;
    raw = a + b;
    r.ovf = 1'b0;
    r.sum = raw;
    if (!a[WIDTH-1] && !b[WIDTH-1] && raw[WIDTH-1]) begin
      r.sum = SAT_MAX;
      r.ovf = 1'b1;
    end else if (a[WIDTH-1] && b[WIDTH-1] && !raw[WIDTH-1]) begin
      r.sum = SAT_MIN;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

  assign add_res = sat_add(acc_q, s.in_data);

  // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (s.in_valid) begin
            acc_d = add_res.sum;
            sat_d = sat_q | add_res.ovf;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // Samples are refused here, so the restart cannot collide with an accept.
          if (s.out_ready) begin
            state_d = ST_ACC;
            acc_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so all registers sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign s.in_ready  = (state_q == ST_ACC);
  assign s.out_valid = (state_q == ST_HOLD);
  assign s.out_data  = acc_q;
  assign s.out_sat   = sat_q;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Self-checking bench for signed_sat_accumulator (WIDTH=4, FRAME_LEN=4): table-driven frames
// plus hand-written reset, backpressure and clear sequences, with a result scoreboard.
module tb_signed_sat_accumulator;

  logic clk;
  logic rst_n;
  logic clear;

  signed_sat_accumulator_if #(.WIDTH(4)) ifc ();

  signed_sat_accumulator #(.WIDTH(4), .FRAME_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .s     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       s;
  } res_t;

  typedef struct {
    logic [3:0] smp [4];
    logic [3:0] exp_d;
    logic       exp_s;
  } vec_t;

  res_t sb_q [$];
  vec_t vecs [8];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int ed, input logic es);
    vec_t v;
    v.smp[0] = 4'(a);
    v.smp[1] = 4'(b);
    v.smp[2] = 4'(c);
    v.smp[3] = 4'(d);
    v.exp_d  = 4'(ed);
    v.exp_s  = es;
    return v;
  endfunction

  // Result monitor: inputs change just after posedge, so the negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        check("result_data", $signed(ifc.out_data), $signed(e.d));
        check("result_sat", {31'b0, ifc.out_sat}, {31'b0, e.s});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    while (!ifc.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("accept_timeout", {31'b0, ifc.in_ready}, 1);
    step();
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  task automatic run_frame(input vec_t v);
    sb_q.push_back('{d: v.exp_d, s: v.exp_s});
    for (int i = 0; i < 4; i++) send(v.smp[i]);
    drain();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, {31'b0, ifc.in_ready}, 1);
    check({tag, "_out_valid"}, {31'b0, ifc.out_valid}, 0);
    check({tag, "_out_data"}, $signed(ifc.out_data), 0);
    check({tag, "_out_sat"}, {31'b0, ifc.out_sat}, 0);
  endtask

  initial begin
    vecs[0] = mk( 1,  2, -1,  3,  5, 1'b0);
    vecs[1] = mk( 4,  7, -3,  1,  5, 1'b1);
    vecs[2] = mk(-4, -7, -8,  2, -6, 1'b1);
    vecs[3] = mk( 1,  1,  1,  1,  4, 1'b0);
    vecs[4] = mk( 7,  1, -1,  0,  6, 1'b1);
    vecs[5] = mk(-8, -1,  0,  0, -8, 1'b1);
    vecs[6] = mk(-1, -1, -1, -1, -4, 1'b0);
    vecs[7] = mk( 7, -8,  7, -8, -2, 1'b0);

    rst_n         = 1'b0;
    clear         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    step();
    step();
    check_idle("por");
    rst_n = 1'b1;
    step();

    // Table-driven frames.
    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // out_valid is a single-cycle pulse right after the last accept when the consumer is ready.
    sb_q.push_back('{d: 4'd5, s: 1'b0});
    send(4'd1); send(4'd2); send(4'hF);
    send(4'd3);
    check("pulse_hi", {31'b0, ifc.out_valid}, 1);
    step();
    check("pulse_lo", {31'b0, ifc.out_valid}, 0);
    drain();

    // Reset mid-frame, then a clean frame.
    send(4'd1); send(4'd1);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    run_frame(vecs[3]);

    // Backpressure: result holds and in_valid is ignored.
    ifc.out_ready = 1'b0;
    sb_q.push_back('{d: 4'd5, s: 1'b0});
    send(4'd3); send(4'd3); send(4'd1); send(4'hE);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 4'd7;
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", {31'b0, ifc.out_valid}, 1);
      check("bp_out_data", $signed(ifc.out_data), 5);
      check("bp_in_ready", {31'b0, ifc.in_ready}, 0);
      step();
    end
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    step();
    check_idle("bp_release");
    check("bp_drained", sb_q.size(), 0);
    run_frame(mk(7, 0, 0, 0, 7, 1'b0));

    // Clear mid-frame drops the offered sample and the partial sum.
    send(4'd5); send(4'd5);
    clear        = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 4'd2;
    step();
    clear        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    check_idle("clr_mid");
    run_frame(vecs[3]);

    // Clear in HOLD discards the held result without a handshake.
    ifc.out_ready = 1'b0;
    send(4'd2); send(4'd2); send(4'd2); send(4'd2);
    check("hold_before_clr", {31'b0, ifc.out_valid}, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_idle("clr_hold");
    ifc.out_ready = 1'b1;
    run_frame(vecs[6]);

    step();
    check("sb_empty_end", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signed_sat_accumulator.md
# signed_sat_accumulator

Streaming frame accumulator for 4-bit signed samples. It sits directly downstream of `signed_add_with_saturation` in the arithmetic datapath and is built around that block's saturating-add rule. It accepts `FRAME_LEN` samples over a valid/ready input and folds each into a running saturating sum. It then presents the frame result, plus a sticky saturation flag, on a valid/ready output and holds it until the consumer takes it.

## Interface

Parameters:
- `WIDTH`, default 4: sample and result width, two's complement.
- `FRAME_LEN`, default 4: samples per frame, ≥ 2.

Ports:
- `clk`  in  1  Single clock, rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset. Release is synchronous to `clk`.
- `clear`  in  1  Synchronous frame abort.
- `in_valid`  in  1  Sample valid.
- `in_ready`  out  1  Block can accept a sample.
- `in_data`  in  WIDTH  Signed sample.
- `out_valid`  out  1  Frame result valid.
- `out_ready`  in  1  Consumer accepts the result.
- `out_data`  out  WIDTH  Signed saturated frame sum.
- `out_sat`  out  1  At least one add in this frame saturated.

## Operation

- State machine with two states:
  - ACC: collecting samples.
  - HOLD: result presented.
- Registers: `acc` (WIDTH), `cnt` (frame counter, `$clog2(FRAME_LEN)` bits), `sat` (sticky), `state`.
- `in_ready = (state == ACC)`.
- `out_valid = (state == HOLD)`.
- `out_data = acc`.
- `out_sat = sat`.
- Input handshake: a sample is taken when `in_valid && in_ready` at a rising edge.
- Saturating add, `acc_next = sat_add(acc, in_data)`:
  - Compute the raw WIDTH-bit wrapped sum.
  - Positive overflow means both operands are non-negative and the raw sign bit is 1. The result is then 2^(WIDTH-1)-1.
  - Negative overflow means both operands are negative and the raw sign bit is 0. The result is then -2^(WIDTH-1).
  - Otherwise the result is the raw sum.
  - On either overflow, `sat` is set to 1.
- Frame counting:
  - The first sample of a frame adds to `acc = 0`.
  - `cnt` increments on each accepted sample.
  - On the accepted sample with `cnt == FRAME_LEN-1`, the next state is HOLD and `cnt` returns to 0.
- Leaving HOLD: on `out_valid && out_ready`, the next state is ACC and `acc` and `sat` return to 0.
  - `in_ready` stays 0 during that HOLD cycle, so no sample is taken in the same cycle as the output handshake.
- Intermediate results are saturated at every step, not only at the end. The result is order-dependent: 7 + 1 − 1 = 6, not 7.
- `clear`:
  - Highest priority after reset, in either state.
  - Forces `acc = 0`, `cnt = 0`, `sat = 0`, state ACC.
  - Any sample offered in that cycle is dropped.
  - A result held in HOLD is discarded.
- Reset (`rst_n` low), at any time including mid-frame or in HOLD:
  - `acc = 0`, `cnt = 0`, `sat = 0`, state ACC.
  - Outputs during reset are therefore `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_sat = 0`.

## Timing

- Latency: `out_valid` rises on the clock edge that accepts the last sample of the frame, so it is visible in the following cycle.
- Throughput is at most one frame per `FRAME_LEN + 1` cycles, because HOLD lasts at least one cycle.
- HOLD is stable while `out_ready = 0`: `out_valid`, `out_data` and `out_sat` do not change, and `in_valid` is ignored.
- `out_valid` never drops without a handshake, `clear`, or reset.
- All outputs come directly from registers or from decoding `state`. There is no combinational path from `in_*` to `out_*`, and no path from `out_ready` to `in_ready`.

## Test plan

All scenarios use `WIDTH = 4`, `FRAME_LEN = 4`.

1. **Reset:** assert `rst_n = 0` mid-frame, after 2 accepted samples. Outputs go immediately to `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_sat = 0`. After release, a new 4-sample frame `1,1,1,1` gives `out_data = 4`.
2. **No saturation:** frame `1, 2, -1, 3` with `out_ready = 1` gives `out_data = 5`, `out_sat = 0`. `out_valid` is high for exactly one cycle, the cycle after the 4th accept.
3. **Positive saturation:** frame `4, 7, -3, 1` gives running sums 4, 7 (saturated), 4, 5. Result is `out_data = 5`, `out_sat = 1`.
4. **Negative saturation:** frame `-4, -7, -8, 2` gives running sums -4, -8, -8, -6. Result is `out_data = -6`, `out_sat = 1`.
5. **Backpressure:** complete frame `3, 3, 1, -2` (result 5), then hold `out_ready = 0` for 5 cycles while driving `in_valid = 1` with `in_data = 7`. During those cycles `out_data` stays 5 and `in_ready` stays 0. Raise `out_ready`: one handshake, then ACC with `acc = 0`. The next frame `7, 0, 0, 0` gives 7.
6. **`clear` mid-frame:** after samples `5, 5` (acc = 7, sat = 1), pulse `clear` together with `in_valid = 1`, `in_data = 2`. The sample is dropped. The next frame `1, 1, 1, 1` gives `out_data = 4`, `out_sat = 0`.
